// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: prioritised stall/bubble vectors, redirect holding register
// and stall-cycle counter. Define PIPE_CTRL_MULDIV_EN to add the multi-cycle mult/div occupancy FSM.
module pipe_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ld_use,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        i_wait,
  input  logic        d_wait,
  input  logic        md_start,
  output logic [4:0]  stall,
  output logic [4:0]  bubble,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic md_stall;

`ifdef PIPE_CTRL_MULDIV_EN
  typedef enum logic [1:0] {
    MD_IDLE,
    MD_BUSY,
    MD_DONE
  } md_state_e;

  localparam logic [5:0] MD_LAST = 6'd31;

  md_state_e  md_state_q, md_state_d;
  logic [5:0] md_cnt_q, md_cnt_d;
  logic       md_stall_raw;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!resetn) begin
      md_state_q <= MD_IDLE;
      md_cnt_q   <= '0;
    end else begin
      md_state_q <= md_state_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    md_state_d   = md_state_q;
    md_cnt_d     = md_cnt_q;
    md_stall_raw = 1'b0;
    case (md_state_q)
      MD_IDLE: begin
        if (md_start) begin
          md_stall_raw = 1'b1;
          md_state_d   = MD_BUSY;
          md_cnt_d     = '0;
        end
      end
      MD_BUSY: begin
        md_stall_raw = 1'b1;
        if (md_cnt_q == MD_LAST) md_state_d = MD_DONE;
        else                     md_cnt_d   = md_cnt_q + 6'd1;
      end
      MD_DONE: begin
        // Result writeback waits for the data bus to free up before accepting a new op.
        if (!d_wait) md_state_d = MD_IDLE;
      end
      default: md_state_d = MD_IDLE;
    endcase
  end

  assign md_stall = resetn & md_stall_raw;
`else
  logic unused_md_start;
  assign unused_md_start = md_start;
  assign md_stall        = 1'b0;
`endif

  assign md_busy = md_stall;

  // Deepest active cause wins; each level freezes the stages up to it and bubbles the next one.
  always_comb begin
    stall  = 5'b00000;
    bubble = 5'b00000;
    if (d_wait) begin
      stall  = 5'b01111;
      bubble = 5'b10000;
    end else if (md_stall) begin
      stall  = 5'b00111;
      bubble = 5'b01000;
    end else if (ld_use) begin
      stall  = 5'b00011;
      bubble = 5'b00100;
    end else if (i_wait) begin
      stall  = 5'b00001;
      bubble = 5'b00010;
    end
  end

  logic        pend_q, pend_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    pend_d      = pend_q;
    pc_d        = pc_q;
    stall_cnt_d = stall_cnt_q;
    if (pend_q) begin
      if (!stall[0] && !i_wait) pend_d = 1'b0;
    end else if (br_taken && !stall[1]) begin
      pend_d = 1'b1;
      pc_d   = br_target;
    end
    if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pend_q      <= 1'b0;
      pc_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      pc_q        <= pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign redirect_valid = pend_q;
  assign redirect_pc    = pc_q;
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a driver pushes model-predicted outputs per cycle, a monitor
// pops and compares at the falling edge. Honours PIPE_CTRL_MULDIV_EN like the design.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, ld_use, br_taken, i_wait, d_wait, md_start;
  logic [31:0] br_target;
  logic [4:0]  stall, bubble;
  logic        redirect_valid, md_busy;
  logic [31:0] redirect_pc, stall_cnt;

  pipe_ctrl dut (
    .clk           (clk),
    .resetn        (resetn),
    .ld_use        (ld_use),
    .br_taken      (br_taken),
    .br_target     (br_target),
    .i_wait        (i_wait),
    .d_wait        (d_wait),
    .md_start      (md_start),
    .stall         (stall),
    .bubble        (bubble),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .md_busy       (md_busy),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          resetn;
    bit          ld_use;
    bit          br_taken;
    logic [31:0] br_target;
    bit          i_wait;
    bit          d_wait;
    bit          md_start;
  } stim_t;

  typedef struct {
    logic [4:0]  stall;
    logic [4:0]  bubble;
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic [31:0] cnt;
    bit          in_reset;
  } exp_t;

  exp_t  exp_q[$];
  int    checks = 0;
  int    errors = 0;
  stim_t cur;

  // Reference state: redirect slot, saturating count, and mult/div as "cycles left" + done flag.
  bit          m_pend = 1'b0;
  logic [31:0] m_pc = '0;
  longint      m_cnt = 0;
  int          m_md_left = 0;
  bit          m_md_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.resetn = 1'b1; s.ld_use = 1'b0; s.br_taken = 1'b0; s.br_target = '0;
    s.i_wait = 1'b0; s.d_wait = 1'b0; s.md_start = 1'b0;
    return s;
  endfunction

  function automatic bit md_active(input stim_t s);
    return s.resetn && MD_EN &&
           (m_md_left > 0 || (m_md_left == 0 && !m_md_done && s.md_start));
  endfunction

  // Number of pipeline stages frozen, counted from fetch upward.
  function automatic int depth(input stim_t s);
    if (s.d_wait)        return 4;
    if (md_active(s))    return 3;
    if (s.ld_use)        return 2;
    if (s.i_wait)        return 1;
    return 0;
  endfunction

  function automatic exp_t predict(input stim_t s);
    exp_t e;
    int   n;
    n          = depth(s);
    e.stall    = 5'((1 << n) - 1);
    e.bubble   = (n == 0) ? 5'd0 : 5'(1 << n);
    e.rv       = m_pend;
    e.rpc      = m_pc;
    e.busy     = md_active(s);
    e.cnt      = m_cnt[31:0];
    e.in_reset = !s.resetn;
    return e;
  endfunction

  task automatic model_step(input stim_t s);
    int n;
    n = depth(s);
    if (!s.resetn) begin
      m_pend = 1'b0; m_pc = '0; m_cnt = 0; m_md_left = 0; m_md_done = 1'b0;
    end else begin
      if (m_pend) begin
        if (n == 0) m_pend = 1'b0;
      end else if (s.br_taken && n < 2) begin
        m_pend = 1'b1;
        m_pc   = s.br_target;
      end
      if (n > 0 && m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      if (MD_EN) begin
        if (m_md_left > 0) begin
          m_md_left--;
          if (m_md_left == 0) m_md_done = 1'b1;
        end else if (m_md_done) begin
          if (!s.d_wait) m_md_done = 1'b0;
        end else if (s.md_start) begin
          m_md_left = 32;
        end
      end
    end
  endtask

  task automatic apply(input stim_t s);
    resetn = s.resetn; ld_use = s.ld_use; br_taken = s.br_taken; br_target = s.br_target;
    i_wait = s.i_wait; d_wait = s.d_wait; md_start = s.md_start;
    cur = s;
  endtask

  task automatic drive_cycle(input stim_t s, input bit do_force);
    @(posedge clk);
    model_step(cur);
    #1;
    apply(s);
    if (do_force) begin
      force dut.stall_cnt_q = 32'hFFFF_FFFE;
      m_cnt = 64'hFFFF_FFFE;
    end
    exp_q.push_back(predict(s));
    if (do_force) begin
      #1;
      release dut.stall_cnt_q;
    end
  endtask

  task automatic repeat_idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(idle(), 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", 32'(stall), 32'(e.stall));
        check("bubble", 32'(bubble), 32'(e.bubble));
        check("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        check("redirect_pc", redirect_pc, e.rpc);
        check("stall_cnt", stall_cnt, e.cnt);
        if (!e.in_reset) check("md_busy", 32'(md_busy), 32'(e.busy));
      end
    end
  end

  initial begin : driver
    stim_t s;
    s = idle();
    s.resetn = 1'b0;
    apply(s);
    drive_cycle(s, 1'b0);
    drive_cycle(s, 1'b0);

    // All lower-priority causes together: the data-bus wait must dominate.
    s = idle(); s.d_wait = 1'b1; s.ld_use = 1'b1; s.i_wait = 1'b1;
    drive_cycle(s, 1'b0);
    repeat_idle(1);

    // Redirect captured under an instruction-bus wait, held until fetch accepts it.
    s = idle(); s.br_taken = 1'b1; s.br_target = 32'hBFC0_0100; s.i_wait = 1'b1;
    drive_cycle(s, 1'b0);
    s = idle(); s.i_wait = 1'b1;
    drive_cycle(s, 1'b0);
    drive_cycle(s, 1'b0);
    repeat_idle(2);

    // Redirect blocked by a load-use stall, then taken once decode re-presents it.
    s = idle(); s.br_taken = 1'b1; s.br_target = 32'h8000_1234; s.ld_use = 1'b1;
    drive_cycle(s, 1'b0);
    s.ld_use = 1'b0;
    drive_cycle(s, 1'b0);
    repeat_idle(2);

    // Full mult/div op, then a second op whose DONE state is held by d_wait.
    s = idle(); s.md_start = 1'b1;
    drive_cycle(s, 1'b0);
    repeat_idle(36);
    drive_cycle(s, 1'b0);
    repeat_idle(29);
    s = idle(); s.d_wait = 1'b1;
    for (int i = 0; i < 6; i++) drive_cycle(s, 1'b0);
    repeat_idle(3);

    // Reset lands while the op is mid-flight.
    s = idle(); s.md_start = 1'b1;
    drive_cycle(s, 1'b0);
    repeat_idle(10);
    s = idle(); s.resetn = 1'b0;
    drive_cycle(s, 1'b0);
    repeat_idle(3);

    for (int i = 0; i < 2000; i++) begin
      s.resetn    = ($urandom_range(63) != 0);
      s.ld_use    = ($urandom_range(6) == 0);
      s.br_taken  = ($urandom_range(2) == 0);
      s.br_target = $urandom;
      s.i_wait    = ($urandom_range(3) == 0);
      s.d_wait    = ($urandom_range(9) == 0);
      s.md_start  = ($urandom_range(19) == 0);
      drive_cycle(s, 1'b0);
    end
    s = idle(); s.resetn = 1'b0;
    drive_cycle(s, 1'b0);

    // Counter saturation: real counting, then a preset just below the ceiling.
    s = idle(); s.ld_use = 1'b1;
    for (int i = 0; i < 40; i++) drive_cycle(s, 1'b0);
    drive_cycle(s, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(s, 1'b0);
    repeat_idle(3);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
